updown_mod_counter: RTL
=======================

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (2..32).
REQ-002 SHALL have parameter MODULUS, default 2**WIDTH, count range 0..MODULUS-1 (2..2**WIDTH).
REQ-003 SHALL have parameter PRESCALE, default 1, enabled clock cycles per count step (1..65535).
REQ-004 SHALL have parameter SATURATE, default 0; 0 = wrap at range ends, 1 = hold at range ends.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port reset_n, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-007 SHALL have port en, input, 1, count enable; also gates the prescaler.
REQ-008 SHALL have port up_dn, input, 1, direction: 1 = up, 0 = down.
REQ-009 SHALL have port clr, input, 1, synchronous clear.
REQ-010 SHALL have port load, input, 1, synchronous parallel load.
REQ-011 SHALL have port load_val, input, WIDTH, value for load.
REQ-012 SHALL have port Q, output, WIDTH, registered count.
REQ-013 SHALL have port tc, output, 1, registered terminal-count pulse.
REQ-014 SHALL have port ovf, output, 1, sticky boundary-event flag.

Function
REQ-015 SHALL apply per-edge priority: clr > load > step > hold.
REQ-016 SHALL on clr set Q=0, tc=0, ovf=0, prescaler count=0.
REQ-017 SHALL on load (no clr) set Q=load_val, clamped to MODULUS-1 when load_val >= MODULUS; prescaler count=0; tc=0; ovf unchanged.
REQ-018 SHALL take a step on an edge where en=1, clr=0, load=0 and prescaler tick=1.
REQ-019 SHALL assert tick when prescaler count = PRESCALE-1 with en=1, then return count to 0; count advances only while en=1, holds while en=0; PRESCALE=1 makes tick=en.
REQ-020 SHALL up-step: Q<MODULUS-1 -> Q+1; Q=MODULUS-1 -> 0 (SATURATE=0) or stay MODULUS-1 (SATURATE=1).
REQ-021 SHALL down-step: Q>0 -> Q-1; Q=0 -> MODULUS-1 (SATURATE=0) or stay 0 (SATURATE=1).
REQ-022 SHALL set tc=1 for exactly the cycle following each step taken at a range end (wrap or blocked saturate step); tc=0 otherwise.
REQ-023 SHALL set ovf=1 on any boundary step and hold it until clr or reset.
REQ-024 SHALL give one-cycle latency: Q, tc reflect inputs sampled at the preceding rising edge.
REQ-025 SHALL never present Q >= MODULUS.
REQ-026 SHALL follow up_dn changes on the next step without glitching Q.

Reset
REQ-027 SHALL on reset_n=0 immediately, without a clock edge, force Q=0, tc=0, ovf=0, prescaler count=0.
REQ-028 SHALL resume on the first rising edge after reset_n release, with a full PRESCALE interval before the first step.
REQ-029 SHALL on reset mid-operation discard any pending step or load.

Structure
REQ-030 SHALL place direction constants (DIR_UP=1, DIR_DOWN=0) and mode constants (MODE_WRAP=0, MODE_SAT=1) in shared package counter_pkg.
REQ-031 SHALL implement the prescaler as sub-module clk_prescaler (ports clk, reset_n, en, clr, tick; parameter PRESCALE), cleared by clr or load.
REQ-032 SHALL be fully synchronous to clk apart from reset; no derived or ripple clocks.

Verification (WIDTH=4, MODULUS=10, PRESCALE=1, SATURATE=0 unless stated)
REQ-033 SHALL cover async reset: run to Q=5, drop reset_n between edges -> Q=0, tc=0, ovf=0 before next edge.
REQ-034 SHALL cover up wrap: en=1, up_dn=1 from 0 -> Q=9 after 9 edges; 10th edge Q=0, tc=1 one cycle, ovf=1.
REQ-035 SHALL cover down wrap and load: load_val=12 -> Q=9 (clamped); load 0, up_dn=0, one step -> Q=9, tc pulse; clr with load same cycle -> Q=0.
REQ-036 SHALL cover saturate: SATURATE=1, load 8, count up 3 steps -> Q=9,9,9; tc=1 after steps 2 and 3; ovf=1; down from 0 stays 0.
REQ-037 SHALL cover prescale: PRESCALE=4 -> Q increments every 4th enabled cycle; en low 3 cycles mid-interval -> step delayed exactly 3 cycles.

Source files
------------

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared direction and boundary-mode constants for counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

  // Direction encoding on up_dn
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Boundary behaviour selected by SATURATE
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/clk_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : clk_prescaler
//  Description : Enable-gated cycle divider; emits a one-cycle tick every
//                PRESCALE enabled cycles. tick is a qualified enable, never
//                a clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] c_last = 16'(PRESCALE - 1);

  logic [15:0] r_cnt;

  // Tick on the last enabled cycle of the interval; en=0 freezes the phase
  assign tick = en && (r_cnt == c_last);

  // Interval counter: cleared by reset or clr, advances only while enabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (tick) r_cnt <= '0;
      else      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule : clk_prescaler
`default_nettype wire

// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : updown_mod_counter
//  Description : Up/down modulo-N counter with prescaler, clear, clamped
//                parallel load, wrap or saturate boundary handling, a
//                terminal-count pulse and a sticky boundary flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter int              PRESCALE = 1,
  parameter int              SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 64'd1);
  localparam bit               c_sat = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             r_ovf;

  logic             w_tick;
  logic             w_at_end;
  logic [WIDTH-1:0] w_load_q;
  logic [WIDTH-1:0] w_step_q;

  // A load restarts the step interval just like a clear does
  clk_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .clr     (clr | load),
    .tick    (w_tick)
  );

  // Step target: range-end handling, load clamping and boundary detection
  always_comb begin
    w_at_end = (up_dn == DIR_UP) ? (r_q == c_max) : (r_q == '0);
    w_load_q = (64'(load_val) >= MODULUS) ? c_max : load_val;
    w_step_q = r_q;
    if (w_at_end) begin
      if (!c_sat) w_step_q = (up_dn == DIR_DOWN) ? c_max : '0;
    end else begin
      w_step_q = (up_dn == DIR_UP) ? (r_q + 1'b1) : (r_q - 1'b1);
    end
  end

  // State update with priority clr > load > step > hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q   <= '0;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_q   <= '0;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (load) begin
      r_q   <= w_load_q;
      r_tc  <= 1'b0;
    end else if (w_tick) begin
      r_q   <= w_step_q;
      r_tc  <= w_at_end;
      r_ovf <= r_ovf | w_at_end;
    end else begin
      r_tc  <= 1'b0;
    end
  end

  assign Q   = r_q;
  assign tc  = r_tc;
  assign ovf = r_ovf;

endmodule : updown_mod_counter
`default_nettype wire
